keypad_matrix_emulator: RTL

- Synthesizable model of the physical 4x4 matrix keypad: the passive far end of the scanning interface the keypad controller drives.
- Takes scripted key presses through a valid/ready handshake and closes the selected switch contact with a deterministic LFSR-driven bounce, hold, release-bounce and idle-gap sequence.
- Drives the row lines in response to the controller's column scan, so controller debounce and decode can be exercised in simulation and on an FPGA loopback.

---
 rtl/keypad_if.sv | 34 +++
 rtl/keypad_matrix_emulator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/keypad_if.sv
// Press-request handshake and contact status between a script driver
// and the keypad matrix emulator.
interface keypad_if;
  logic       press_valid;
  logic [3:0] press_key;
  logic       press_ready;
  logic       bounce_en;
  logic       key_down;
  logic       busy;
  logic       done;
  logic [7:0] press_count;

  modport master (
    output press_valid,
    output press_key,
    output bounce_en,
    input  press_ready,
    input  key_down,
    input  busy,
    input  done,
    input  press_count
  );

  modport slave (
    input  press_valid,
    input  press_key,
    input  bounce_en,
    output press_ready,
    output key_down,
    output busy,
    output done,
    output press_count
  );
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 matrix keypad model: scripted presses with LFSR contact
// bounce, answering the controller's column scan on the row lines.
module keypad_matrix_emulator #(
  parameter int         HOLD_CYCLES   = 200,
  parameter int         BOUNCE_CYCLES = 16,
  parameter int         GAP_CYCLES    = 50,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  keypad_if.slave    kp
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BIN  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_BOUT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [31:0] BIN_LD =
    (BOUNCE_CYCLES == 0) ? 32'd0 : 32'(BOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LD =
    (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  logic [2:0]  state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [7:0]  lfsr;
  logic        lfsr_adv;
  logic        fb;
  logic [3:0]  key_r;
  logic        contact;
  logic        key_down_r;
  logic        done_r, done_n;
  logic [7:0]  count_r;
  logic        accept;

  assign accept = (state == S_IDLE) && kp.press_valid;
  // x^8+x^6+x^5+x^4+1, shifting left into bit 0
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt - 32'd1;
    lfsr_adv = 1'b0;
    contact  = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = cnt;
        if (kp.press_valid) begin
          if (HAS_BOUNCE) begin
            state_n = S_BIN;
            cnt_n   = BIN_LD;
          end else begin
            state_n = S_HOLD;
            cnt_n   = HOLD_LD;
          end
        end
      end
      S_BIN: begin
        lfsr_adv = 1'b1;
        contact  = kp.bounce_en ? lfsr[0] : 1'b1;
        if (cnt == 32'd0) begin
          state_n = S_HOLD;
          cnt_n   = HOLD_LD;
        end
      end
      S_HOLD: begin
        contact = 1'b1;
        if (cnt == 32'd0) begin
          if (HAS_BOUNCE) begin
            state_n = S_BOUT;
            cnt_n   = BIN_LD;
          end else begin
            state_n = S_GAP;
            cnt_n   = GAP_LD;
          end
        end
      end
      S_BOUT: begin
        lfsr_adv = 1'b1;
        contact  = kp.bounce_en ? lfsr[0] : 1'b0;
        if (cnt == 32'd0) begin
          state_n = S_GAP;
          cnt_n   = GAP_LD;
        end
      end
      S_GAP: begin
        if (cnt == 32'd0) begin
          state_n = S_IDLE;
          cnt_n   = 32'd0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 32'd0;
      lfsr       <= LFSR_SEED;
      key_r      <= 4'd0;
      key_down_r <= 1'b0;
      done_r     <= 1'b0;
      count_r    <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      key_down_r <= contact;
      done_r     <= done_n;
      if (lfsr_adv)
        lfsr <= {lfsr[6:0], fb};
      if (accept)
        key_r <= kp.press_key;
      if (done_n)
        count_r <= count_r + 8'd1;
    end
  end

  // Closed switch shorts the key's column onto its row (wired-OR)
  always_comb begin
    row             = 4'b0000;
    row[key_r[3:2]] = key_down_r & col[key_r[1:0]];
  end

  assign kp.press_ready = (state == S_IDLE);
  assign kp.busy        = (state != S_IDLE);
  assign kp.key_down    = key_down_r;
  assign kp.done        = done_r;
  assign kp.press_count = count_r;

endmodule
